// File: rtl/freepdk45_sram_pkg.sv
// Shared types and helpers for the parametrised 1w1r SRAM model.
package freepdk45_sram_pkg;

    typedef enum logic {
        INIT,
        READY
    } sram_state_t;

    // Upper bound on word width handled by the shared merge helper.
    localparam int unsigned MAX_WIDTH = 1024;
    localparam int unsigned MAX_IDX_W = $clog2(MAX_WIDTH);

    function automatic int unsigned num_wmasks(input int unsigned data_width,
                                               input int unsigned gran);
        return data_width / gran;
    endfunction

    // Lane i of the mask selects new_word over old_word for bits [i*gran +: gran].
    function automatic logic [MAX_WIDTH-1:0] merge_word(input logic [MAX_WIDTH-1:0] old_word,
                                                        input logic [MAX_WIDTH-1:0] new_word,
                                                        input logic [MAX_WIDTH-1:0] mask,
                                                        input int unsigned          gran);
        logic [MAX_WIDTH-1:0] w;
        logic [MAX_IDX_W-1:0] lane;
        w = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            lane = MAX_IDX_W'(i / gran);
            w[i] = mask[lane] ? new_word[i] : old_word[i];
        end
        return w;
    endfunction

endpackage

// File: rtl/freepdk45_sram_1w1r_array.sv
// Raw DEPTH x DATA_WIDTH storage: masked synchronous write, asynchronous read.
module freepdk45_sram_1w1r_array
    import freepdk45_sram_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 72,
    parameter  int unsigned ADDR_WIDTH = 6,
    parameter  int unsigned DEPTH      = 40,
    parameter  int unsigned WMASK_GRAN = 8,
    localparam int unsigned NUM_WMASKS = num_wmasks(DATA_WIDTH, WMASK_GRAN)
) (
    input  logic                  clk0,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [NUM_WMASKS-1:0] wmask,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] wr_word;

    // The caller only asserts we with waddr < DEPTH.
    always_comb begin
        wr_word = DATA_WIDTH'(merge_word(MAX_WIDTH'(mem[waddr]), MAX_WIDTH'(wdata),
                                         MAX_WIDTH'(wmask), WMASK_GRAN));
    end

    always_ff @(posedge clk0) begin
        if (we) begin
            mem[waddr] <= wr_word;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/freepdk45_sram_1w1r_param.sv
// Parametrised 1w1r SRAM: init sweep FSM, range checks, collision bypass, read pipeline.
module freepdk45_sram_1w1r_param
    import freepdk45_sram_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH    = 72,
    parameter  int unsigned ADDR_WIDTH    = 6,
    parameter  int unsigned DEPTH         = 40,
    parameter  int unsigned WMASK_GRAN    = 8,
    parameter  int unsigned READ_LATENCY  = 1,
    parameter  int unsigned WRITE_FIRST   = 1,
    parameter  int unsigned INIT_ON_RESET = 1,
    localparam int unsigned NUM_WMASKS    = num_wmasks(DATA_WIDTH, WMASK_GRAN)
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    input  logic                  csb0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dout1_vld,
    output logic                  err0,
    output logic                  err1,
    output logic                  init_done
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    if (WMASK_GRAN < 1 || DATA_WIDTH % WMASK_GRAN != 0) begin : g_chk_gran
        $error("DATA_WIDTH must be a non-zero multiple of WMASK_GRAN");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_chk_depth
        $error("DEPTH must lie in 1..2**ADDR_WIDTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_chk_lat
        $error("READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH > MAX_WIDTH) begin : g_chk_width
        $error("DATA_WIDTH exceeds MAX_WIDTH");
    end

    sram_state_t           state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  ready;
    logic                  sweep;
    logic                  wr_req;
    logic                  rd_req;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  collide;
    logic                  arr_we;
    logic [ADDR_WIDTH-1:0] arr_waddr;
    logic [NUM_WMASKS-1:0] arr_wmask;
    logic [DATA_WIDTH-1:0] arr_wdata;
    logic [DATA_WIDTH-1:0] arr_rdata;
    logic [DATA_WIDTH-1:0] rd_word;

    always_comb begin
        ready       = (state == READY);
        sweep       = (state == INIT) && (INIT_ON_RESET != 0);
        wr_req      = ready && !csb0;
        rd_req      = ready && !csb1;
        wr_in_range = ({1'b0, addr0} < DEPTH_LIM);
        rd_in_range = ({1'b0, addr1} < DEPTH_LIM);
        collide     = wr_req && wr_in_range && rd_req && (addr0 == addr1);
    end

    always_comb begin
        arr_we    = sweep || (wr_req && wr_in_range);
        arr_waddr = sweep ? cnt : addr0;
        arr_wmask = sweep ? '1  : wmask0;
        arr_wdata = sweep ? '0  : din0;
    end

    freepdk45_sram_1w1r_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .WMASK_GRAN (WMASK_GRAN)
    ) u_array (
        .clk0  (clk0),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wmask (arr_wmask),
        .wdata (arr_wdata),
        .raddr (addr1),
        .rdata (arr_rdata)
    );

    // The array read is combinational, so arr_rdata is still the pre-write word on a collision.
    always_comb begin
        rd_word = arr_rdata;
        if (!rd_in_range) begin
            rd_word = '0;
        end else if (collide && WRITE_FIRST != 0) begin
            rd_word = DATA_WIDTH'(merge_word(MAX_WIDTH'(arr_rdata), MAX_WIDTH'(din0),
                                             MAX_WIDTH'(wmask0), WMASK_GRAN));
        end
    end

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            state     <= INIT;
            cnt       <= '0;
            init_done <= 1'b0;
            err0      <= 1'b0;
        end else begin
            err0 <= wr_req && !wr_in_range;
            case (state)
                INIT: begin
                    if (INIT_ON_RESET == 0 || cnt == LAST_ADDR) begin
                        state     <= READY;
                        init_done <= 1'b1;
                    end else begin
                        cnt <= cnt + ADDR_WIDTH'(1);
                    end
                end
                READY: state <= READY;
                default: state <= INIT;
            endcase
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  p_vld;
        logic                  p_err;
        logic [DATA_WIDTH-1:0] p_data;

        always_ff @(posedge clk0 or negedge rstb0) begin
            if (!rstb0) begin
                p_vld     <= 1'b0;
                p_err     <= 1'b0;
                p_data    <= '0;
                dout1     <= '0;
                dout1_vld <= 1'b0;
                err1      <= 1'b0;
            end else begin
                p_vld     <= rd_req;
                p_err     <= rd_req && !rd_in_range;
                if (rd_req) begin
                    p_data <= rd_word;
                end
                dout1_vld <= p_vld;
                err1      <= p_err;
                if (p_vld) begin
                    dout1 <= p_data;
                end
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clk0 or negedge rstb0) begin
            if (!rstb0) begin
                dout1     <= '0;
                dout1_vld <= 1'b0;
                err1      <= 1'b0;
            end else begin
                dout1_vld <= rd_req;
                err1      <= rd_req && !rd_in_range;
                if (rd_req) begin
                    dout1 <= rd_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_freepdk45_sram_1w1r_param.sv
// Randomised scoreboard bench: two configurations (latency 1 write-first, latency 2 read-first).
module tb_freepdk45_sram_1w1r_param;

    localparam int unsigned DW    = 72;
    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 40;
    localparam int unsigned GRAN  = 8;
    localparam int unsigned NW    = DW / GRAN;

    logic          clk0 = 1'b0;
    logic          rstb0;
    logic          csb0;
    logic          csb1;
    logic [NW-1:0] wmask0;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] din0;

    logic [DW-1:0] dout_a, dout_b;
    logic          vld_a, vld_b, e0_a, e0_b, e1_a, e1_b, id_a, id_b;

    always #5 clk0 = ~clk0;

    freepdk45_sram_1w1r_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WMASK_GRAN(GRAN),
        .READ_LATENCY(1), .WRITE_FIRST(1), .INIT_ON_RESET(1)
    ) dut_a (
        .clk0(clk0), .rstb0(rstb0), .csb0(csb0), .wmask0(wmask0), .addr0(addr0),
        .din0(din0), .csb1(csb1), .addr1(addr1), .dout1(dout_a), .dout1_vld(vld_a),
        .err0(e0_a), .err1(e1_a), .init_done(id_a)
    );

    freepdk45_sram_1w1r_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WMASK_GRAN(GRAN),
        .READ_LATENCY(2), .WRITE_FIRST(0), .INIT_ON_RESET(1)
    ) dut_b (
        .clk0(clk0), .rstb0(rstb0), .csb0(csb0), .wmask0(wmask0), .addr0(addr0),
        .din0(din0), .csb1(csb1), .addr1(addr1), .dout1(dout_b), .dout1_vld(vld_b),
        .err0(e0_b), .err1(e1_b), .init_done(id_b)
    );

    int unsigned   n_checks = 0;
    int unsigned   n_errors = 0;
    int unsigned   edge_n;
    logic [DW-1:0] mem [DEPTH];
    int unsigned   lat [2] = '{1, 2};
    bit            wf  [2] = '{1'b1, 1'b0};
    bit            pend_vld  [2][4];
    bit            pend_err  [2][4];
    logic [DW-1:0] pend_data [2][4];
    bit            exp_vld  [2];
    bit            exp_err1 [2];
    logic [DW-1:0] exp_dout [2];
    bit            exp_err0;
    bit            exp_init;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_w,
                                                 input logic [DW-1:0] new_w,
                                                 input logic [NW-1:0] m);
        logic [DW-1:0] r = old_w;
        for (int l = 0; l < NW; l++) begin
            if (m[l]) r[l*GRAN +: GRAN] = new_w[l*GRAN +: GRAN];
        end
        return r;
    endfunction

    task automatic model_reset();
        edge_n = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 4; s++) begin
                pend_vld[d][s]  = 1'b0;
                pend_err[d][s]  = 1'b0;
                pend_data[d][s] = '0;
            end
            exp_vld[d]  = 1'b0;
            exp_err1[d] = 1'b0;
            exp_dout[d] = '0;
        end
        exp_err0 = 1'b0;
        exp_init = 1'b0;
    endtask

    // One posedge with reset released: requests are honoured once the DEPTH-cycle sweep is over.
    task automatic model_edge();
        bit            acc;
        bit            rerr;
        logic [DW-1:0] val;
        int unsigned   slot;
        edge_n++;
        acc      = (edge_n > DEPTH);
        exp_err0 = acc && !csb0 && (int'(addr0) >= DEPTH);
        if (acc && !csb1) begin
            rerr = (int'(addr1) >= DEPTH);
            for (int d = 0; d < 2; d++) begin
                if (rerr) val = '0;
                else if (!csb0 && addr0 == addr1 && wf[d]) val = lane_merge(mem[addr1], din0, wmask0);
                else val = mem[addr1];
                slot = (edge_n + lat[d] - 1) % 4;
                pend_vld[d][slot]  = 1'b1;
                pend_err[d][slot]  = rerr;
                pend_data[d][slot] = val;
            end
        end
        if (acc && !csb0 && int'(addr0) < DEPTH) mem[addr0] = lane_merge(mem[addr0], din0, wmask0);
        for (int d = 0; d < 2; d++) begin
            slot = edge_n % 4;
            exp_vld[d]  = pend_vld[d][slot];
            exp_err1[d] = pend_vld[d][slot] && pend_err[d][slot];
            if (pend_vld[d][slot]) exp_dout[d] = pend_data[d][slot];
            pend_vld[d][slot] = 1'b0;
        end
        exp_init = (edge_n >= DEPTH);
    endtask

    task automatic check_dut(input int d, input logic [DW-1:0] dv, input logic v,
                             input logic er0, input logic er1, input logic id);
        check($sformatf("dut%0d.dout1", d), dv, exp_dout[d]);
        check($sformatf("dut%0d.dout1_vld", d), DW'(v), DW'(exp_vld[d]));
        check($sformatf("dut%0d.err1", d), DW'(er1), DW'(exp_err1[d]));
        check($sformatf("dut%0d.err0", d), DW'(er0), DW'(exp_err0));
        check($sformatf("dut%0d.init_done", d), DW'(id), DW'(exp_init));
    endtask

    task automatic check_all();
        check_dut(0, dout_a, vld_a, e0_a, e1_a, id_a);
        check_dut(1, dout_b, vld_b, e0_b, e1_b, id_b);
    endtask

    task automatic step();
        @(posedge clk0);
        if (rstb0) model_edge();
        #1 check_all();
    endtask

    task automatic idle();
        csb0 = 1'b1;
        csb1 = 1'b1;
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d, input logic [NW-1:0] m);
        csb0   = 1'b0;
        addr0  = AW'(a);
        din0   = d;
        wmask0 = m;
    endtask

    task automatic do_read(input int a);
        csb1  = 1'b0;
        addr1 = AW'(a);
    endtask

    // Asserted between edges so the zeroing of outputs is seen as asynchronous.
    task automatic do_reset(input int hold);
        #2 rstb0 = 1'b0;
        model_reset();
        #1 check_all();
        idle();
        repeat (hold) step();
        rstb0 = 1'b1;
    endtask

    task automatic random_traffic(input int cycles);
        repeat (cycles) begin
            csb0   = ($urandom_range(0, 2) == 0);
            csb1   = ($urandom_range(0, 2) == 0);
            addr0  = AW'($urandom_range(0, 47));
            addr1  = ($urandom_range(0, 3) == 0) ? addr0 : AW'($urandom_range(0, 63));
            wmask0 = ($urandom_range(0, 7) == 0) ? '0 : NW'($urandom());
            din0   = DW'({$urandom(), $urandom(), $urandom()});
            step();
        end
        idle();
        repeat (3) step();
    endtask

    initial begin
        rstb0  = 1'b0;
        wmask0 = '0;
        addr0  = '0;
        addr1  = '0;
        din0   = '0;
        idle();
        model_reset();
        #1 check_all();
        repeat (2) step();
        rstb0 = 1'b1;
        repeat (DEPTH) step();

        do_read(39);
        step(); idle(); repeat (2) step();

        do_write(5, 72'hFF_FFFF_FFFF_FFFF_FFFF, 9'h001);
        step(); idle();
        do_read(5);
        step(); idle(); repeat (2) step();

        do_write(3, 72'h12_3456_789A_BCDE_F0AB, 9'h1FF);
        do_read(3);
        step(); idle();
        do_read(3);
        step(); idle(); repeat (2) step();

        do_write(45, 72'hAA_AAAA_AAAA_AAAA_AAAA, 9'h1FF);
        step(); idle();
        do_read(63);
        step(); idle(); repeat (2) step();

        for (int a = 0; a < 3; a++) begin
            do_read(a);
            step();
        end
        idle(); repeat (3) step();

        random_traffic(600);

        do_read(7);
        step();
        do_reset(2);
        repeat (10) step();
        do_reset(1);
        repeat (DEPTH) step();

        for (int a = 0; a < 6; a++) begin
            do_read(a);
            step();
        end
        idle(); repeat (2) step();
        random_traffic(150);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
